// File: rtl/timer_intr_gen_if.sv
`timescale 1ns/1ps
// Peripheral bus between the core-side master and the timer register block.
// A word is selected by addr_i, and stores are byte-laned through mask.
interface timer_intr_gen_if #(
    parameter int DW = 32
);
    logic          cs;
    logic          we;
    logic [2:0]    addr_i;
    logic [DW-1:0] wdata_i;
    logic [3:0]    mask;
    logic [DW-1:0] rdata_o;

    modport master (
        output cs, we, addr_i, wdata_i, mask,
        input  rdata_o
    );

    modport slave (
        input  cs, we, addr_i, wdata_i, mask,
        output rdata_o
    );
endinterface

// File: rtl/timer_intr_gen.sv
`timescale 1ns/1ps
// Machine timer with a programmable prescaler.
// mtime counts prescaler ticks. A compare match against mtimecmp raises a
// sticky PENDING flag, which is write-1-to-clear. In periodic mode the match
// also reloads mtime to zero. The layout assumes DW = 32, so the 64-bit
// mtime and mtimecmp each occupy two bus words and mask covers four lanes.
module timer_intr_gen #(
    parameter int DW      = 32,
    parameter int PRESC_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    timer_intr_gen_if.slave bus,
    output logic            t_intr
);
    localparam int MW = 2 * DW;

    typedef enum logic [2:0] {
        REG_MTIME_LO = 3'd0,
        REG_MTIME_HI = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_CTRL     = 3'd4,
        REG_PRESC    = 3'd5,
        REG_STATUS   = 3'd6,
        REG_RSVD     = 3'd7
    } reg_idx_e;

    reg_idx_e           addr;
    logic [MW-1:0]      mtime, mtime_nxt;
    logic [MW-1:0]      mtimecmp, mtimecmp_nxt;
    logic [PRESC_W-1:0] pcnt, pcnt_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic               en, en_nxt;
    logic               periodic, periodic_nxt;
    logic               ie, ie_nxt;
    logic               pending, pending_nxt;
    logic               wr, tick, match, set_pend, clr_pend;

    assign addr = reg_idx_e'(bus.addr_i);

    // Each bit takes the new value only when its byte lane is enabled.
    function automatic logic [DW-1:0] merge_lanes(
        input logic [DW-1:0] old_val,
        input logic [DW-1:0] new_val,
        input logic [3:0]    lanes
    );
        logic [DW-1:0] res;
        for (int b = 0; b < DW; b++) begin
            res[b] = lanes[b / 8] ? new_val[b] : old_val[b];
        end
        return res;
    endfunction

    // Combinational load path. The result is zero unless this is a selected read.
    always_comb begin
        bus.rdata_o = '0;
        if (bus.cs && !bus.we) begin
            case (addr)
                REG_MTIME_LO: bus.rdata_o = mtime[DW-1:0];
                REG_MTIME_HI: bus.rdata_o = mtime[MW-1:DW];
                REG_CMP_LO:   bus.rdata_o = mtimecmp[DW-1:0];
                REG_CMP_HI:   bus.rdata_o = mtimecmp[MW-1:DW];
                REG_CTRL:     bus.rdata_o[2:0] = {ie, periodic, en};
                REG_PRESC:    bus.rdata_o[PRESC_W-1:0] = presc;
                REG_STATUS:   bus.rdata_o[0] = pending;
                default:      bus.rdata_o = '0;
            endcase
        end
    end

    // Next-state logic: counting first, then software writes override it.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        wr           = bus.cs && bus.we;
        match        = (mtime >= mtimecmp);
        tick         = en && (pcnt == presc);
        pcnt_nxt     = pcnt;
        mtime_nxt    = mtime;
        mtimecmp_nxt = mtimecmp;
        presc_nxt    = presc;
        en_nxt       = en;
        periodic_nxt = periodic;
        ie_nxt       = ie;
        clr_pend     = 1'b0;

        if (en) begin
            pcnt_nxt = tick ? '0 : pcnt + PRESC_W'(1);
        end
        if (tick) begin
            mtime_nxt = (periodic && match) ? '0 : mtime + MW'(1);
        end

        // One-shot mode flags every enabled cycle in match. Periodic mode flags only at the reload tick.
        set_pend = en && match && (!periodic || tick);

        if (wr) begin
            case (addr)
                // A write to either half cancels that cycle's tick for the whole
                // counter, so the untouched half keeps its pre-write value.
                REG_MTIME_LO: mtime_nxt = {mtime[MW-1:DW],
                                           merge_lanes(mtime[DW-1:0], bus.wdata_i, bus.mask)};
                REG_MTIME_HI: mtime_nxt = {merge_lanes(mtime[MW-1:DW], bus.wdata_i, bus.mask),
                                           mtime[DW-1:0]};
                REG_CMP_LO:   mtimecmp_nxt = {mtimecmp[MW-1:DW],
                                              merge_lanes(mtimecmp[DW-1:0], bus.wdata_i, bus.mask)};
                REG_CMP_HI:   mtimecmp_nxt = {merge_lanes(mtimecmp[MW-1:DW], bus.wdata_i, bus.mask),
                                              mtimecmp[DW-1:0]};
                REG_CTRL: begin
                    if (bus.mask[0]) begin
                        {ie_nxt, periodic_nxt, en_nxt} = bus.wdata_i[2:0];
                    end
                end
                REG_PRESC: begin
                    for (int b = 0; b < PRESC_W; b++) begin
                        if (bus.mask[b / 8]) begin
                            presc_nxt[b] = bus.wdata_i[b];
                        end
                    end
                    // A new reload value always restarts the prescaler period.
                    pcnt_nxt = '0;
                end
                REG_STATUS:   clr_pend = bus.wdata_i[0] && bus.mask[0];
                default:      ;
            endcase
        end

        // A set in the same cycle wins over a clear.
        pending_nxt = set_pend || (pending && !clr_pend);
    end

    // State registers, forced to reset values asynchronously while rst_i is low.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime    <= '0;
            mtimecmp <= '1;
            pcnt     <= '0;
            presc    <= '0;
            en       <= 1'b0;
            periodic <= 1'b0;
            ie       <= 1'b0;
            pending  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge values together.
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            pcnt     <= pcnt_nxt;
            presc    <= presc_nxt;
            en       <= en_nxt;
            periodic <= periodic_nxt;
            ie       <= ie_nxt;
            pending  <= pending_nxt;
        end
    end

    // The interrupt is driven only from flops, so no bus input reaches it combinationally.
    assign t_intr = pending & ie;
endmodule
